weight_stream_loader: RTL

Sequencer sitting directly downstream of the weight ROM in the systolic-array datapath. On a start command it walks one weight file of the ROM in row-major order, driving the ROM's file/row/column address inputs and capturing its combinational read data. It then streams the weights, one per beat, to the array's weight-injection port over a valid/ready handshake, tagged with row/column indices and a last flag.

---
 rtl/weight_stream_loader.sv | 118 +++++++++++
 1 files changed

// File: rtl/weight_stream_loader.sv
// Streams one weight file from the combinational weight ROM, in row-major order,
// to the systolic-array injection port over a valid/ready handshake.
module weight_stream_loader #(
    parameter int ROWS      = 64,
    parameter int COLS      = 64,
    parameter int NUM_FILES = 10,
    parameter int W         = 32,
    parameter int A         = 12
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [A-1:0] file_sel,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [A-1:0] rom_file,
    output logic [A-1:0] rom_row,
    output logic [A-1:0] rom_col,
    input  logic [W-1:0] rom_data,
    output logic [W-1:0] w_data,
    output logic [A-1:0] w_row,
    output logic [A-1:0] w_col,
    output logic         w_last,
    output logic         w_valid,
    input  logic         w_ready
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

    localparam logic [A-1:0] LAST_ROW   = A'(ROWS - 1);
    localparam logic [A-1:0] LAST_COL   = A'(COLS - 1);
    localparam logic [A:0]   FILE_LIMIT = (A + 1)'(NUM_FILES);

    state_t state;
    logic   load;
    logic   at_last;
    logic   file_ok;

    // The output register can take a new beat when empty or when its beat is being accepted.
    assign load    = !w_valid || w_ready;
    assign at_last = (rom_row == LAST_ROW) && (rom_col == LAST_COL);
    assign file_ok = {1'b0, file_sel} < FILE_LIMIT;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            rom_file <= '0;
            rom_row  <= '0;
            rom_col  <= '0;
            w_data   <= '0;
            w_row    <= '0;
            w_col    <= '0;
            w_last   <= 1'b0;
            w_valid  <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (file_ok) begin
                            rom_file <= file_sel;
                            rom_row  <= '0;
                            rom_col  <= '0;
                            busy     <= 1'b1;
                            state    <= RUN;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (load) begin
                        w_data  <= rom_data;
                        w_row   <= rom_row;
                        w_col   <= rom_col;
                        w_last  <= at_last;
                        w_valid <= 1'b1;
                        // Counters park on the final address until DONE clears them.
                        if (at_last) begin
                            state <= DRAIN;
                        end else if (rom_col == LAST_COL) begin
                            rom_col <= '0;
                            rom_row <= rom_row + 1'b1;
                        end else begin
                            rom_col <= rom_col + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (w_ready) begin
                        w_valid <= 1'b0;
                        w_last  <= 1'b0;
                        busy    <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b1;
                    rom_row <= '0;
                    rom_col <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
